// File: rtl/im_pkg.sv
// Shared constants for the instruction-memory loader: memory geometry and FSM state codes.
package im_pkg;

   localparam int IM_ADDR_W  = 16;
   localparam int INSTR_W    = 32;
   localparam int WORD_BYTES = 4;
   localparam int BCNT_W     = $clog2(WORD_BYTES);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RECV  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // Advance a word index by one; wraps modulo the index width.
   function automatic logic [IM_ADDR_W-3:0] next_word_idx(input logic [IM_ADDR_W-3:0] idx);
      return idx + 1'b1;
   endfunction

endpackage

// File: rtl/im_word_packer.sv
// Assembles four accepted stream bytes into one little-endian instruction word.
module im_word_packer
   import im_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         in_byte,
   input  logic               accept,
   input  logic               clear,
   output logic [INSTR_W-1:0] word,
   output logic               full
);

   logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
   logic [INSTR_W-1:0] word_q, word_d;

   // The word register is never cleared by a new load; every lane is overwritten before it is written out.
   always_comb begin
      bcnt_d = bcnt_q;
      word_d = word_q;
      if (clear) begin
         bcnt_d = '0;
      end else if (accept) begin
         word_d[{bcnt_q, 3'b000} +: 8] = in_byte;
         bcnt_d = bcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bcnt_q <= '0;
         word_q <= '0;
      end else begin
         bcnt_q <= bcnt_d;
         word_q <= word_d;
      end
   end

   assign word = word_q;
   assign full = accept && !clear && (bcnt_q == BCNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/im_loader.sv
// Run-time writer for the instruction memory: packs a byte stream into words and
// writes them at consecutive word addresses while holding the processor in reset.
module im_loader
   import im_pkg::*;
#(
   parameter int ADDR_W    = IM_ADDR_W,
   parameter int BASE_ADDR = 0,
   parameter int LEN_W     = 14
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [LEN_W-1:0]   len,
   input  logic               in_valid,
   input  logic [7:0]         in_byte,
   output logic               in_ready,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [INSTR_W-1:0] wr_data,
   output logic               cpu_hold,
   output logic               busy,
   output logic               done
);

   localparam logic [ADDR_W-1:0] BASE_BYTE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-3:0] BASE_IDX  = BASE_BYTE[ADDR_W-1:2];

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-3:0] widx_q, widx_d;
   logic [LEN_W-1:0]  wcnt_q, wcnt_d;
   logic [LEN_W-1:0]  len_q, len_d;

   logic start_ok;
   logic byte_accept;
   logic word_full;

   assign start_ok    = start && (state_q == S_IDLE);
   assign byte_accept = in_valid && (state_q == S_RECV);

   im_word_packer u_packer (
      .clk     (clk),
      .reset   (reset),
      .in_byte (in_byte),
      .accept  (byte_accept),
      .clear   (start_ok),
      .word    (wr_data),
      .full    (word_full)
   );

   // Word index is kept without the two low address bits so wr_addr stays word aligned.
   always_comb begin
      state_d = state_q;
      widx_d  = widx_q;
      wcnt_d  = wcnt_q;
      len_d   = len_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d   = len;
               widx_d  = BASE_IDX;
               wcnt_d  = '0;
               state_d = (len == '0) ? S_DONE : S_RECV;
            end
         end
         S_RECV: begin
            if (word_full) begin
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            widx_d  = next_word_idx(widx_q);
            wcnt_d  = wcnt_q + 1'b1;
            state_d = (wcnt_d == len_q) ? S_DONE : S_RECV;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         widx_q  <= BASE_IDX;
         wcnt_q  <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         widx_q  <= widx_d;
         wcnt_q  <= wcnt_d;
         len_q   <= len_d;
      end
   end

   assign in_ready = (state_q == S_RECV);
   assign wr_en    = (state_q == S_WRITE);
   assign wr_addr  = {widx_q, 2'b00};
   assign busy     = (state_q == S_RECV) || (state_q == S_WRITE);
   assign done     = (state_q == S_DONE);
   assign cpu_hold = (state_q != S_IDLE);

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: one instance at base 0x0000 and one at base 0xFFFC share all inputs.
module tb_im_loader;

   logic        clk = 1'b0;
   logic        reset, start, in_valid;
   logic [13:0] len;
   logic [7:0]  in_byte;

   logic        in_ready0, wr_en0, cpu_hold0, busy0, done0;
   logic [15:0] wr_addr0;
   logic [31:0] wr_data0;
   logic        in_ready1, wr_en1, cpu_hold1, busy1, done1;
   logic [15:0] wr_addr1;
   logic [31:0] wr_data1;

   int testsRun = 0;
   int failCount = 0;
   int timeouts = 0;
   int doneCount = 0;
   int holdDrop = 0;
   int readyInWrite = 0;
   bit watchHold = 1'b0;

   logic [15:0] addrLog0[$];
   logic [31:0] dataLog0[$];
   logic [15:0] addrLog1[$];
   logic [31:0] dataLog1[$];

   always #5 clk = ~clk;

   im_loader #(.ADDR_W(16), .BASE_ADDR(0), .LEN_W(14)) dut0 (
      .clk(clk), .reset(reset), .start(start), .len(len),
      .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready0),
      .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
      .cpu_hold(cpu_hold0), .busy(busy0), .done(done0)
   );

   im_loader #(.ADDR_W(16), .BASE_ADDR(16'hFFFC), .LEN_W(14)) dut1 (
      .clk(clk), .reset(reset), .start(start), .len(len),
      .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready1),
      .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
      .cpu_hold(cpu_hold1), .busy(busy1), .done(done1)
   );

   // Record every memory write and pulse mid-cycle, away from the clock edge.
   always @(negedge clk) begin
      if (wr_en0) begin
         addrLog0.push_back(wr_addr0);
         dataLog0.push_back(wr_data0);
         if (in_ready0) readyInWrite++;
      end
      if (wr_en1) begin
         addrLog1.push_back(wr_addr1);
         dataLog1.push_back(wr_data1);
      end
      if (done0) doneCount++;
      if (watchHold && !(cpu_hold0 && busy0)) holdDrop++;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic clearLogs();
      addrLog0.delete();
      dataLog0.delete();
      addrLog1.delete();
      dataLog1.delete();
      doneCount = 0;
   endtask

   task automatic pulseStart(input logic [13:0] n);
      start = 1'b1;
      len   = n;
      step();
      start = 1'b0;
   endtask

   // Present one byte after a random idle gap and hold it until the loader takes it.
   task automatic applyStimulus(input logic [7:0] b, input int maxGap);
      int gap;
      int n;
      gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
         in_byte = 8'($urandom);
         step();
      end
      in_byte  = b;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready0 && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) timeouts++;
      else step();
      in_valid = 1'b0;
   endtask

   task automatic sendWord(input logic [31:0] w, input int maxGap);
      logic [31:0] v;
      v = w;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(v[8*i +: 8], maxGap);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_byte = '0;
      step();
      step();
      reset = 1'b0;
      step();
      checkOutput("reset_in_ready", in_ready0, 0);
      checkOutput("reset_wr_en", wr_en0, 0);
      checkOutput("reset_wr_addr", wr_addr0, 0);
      checkOutput("reset_wr_data", wr_data0, 0);
      checkOutput("reset_cpu_hold", cpu_hold0, 0);
      checkOutput("reset_busy", busy0, 0);
      checkOutput("reset_done", done0, 0);
      checkOutput("reset_wr_addr_base_fffc", wr_addr1, 32'hFFFC);

      // T1: single word, back-to-back bytes
      clearLogs();
      pulseStart(14'd1);
      checkOutput("t1_busy_after_start", busy0, 1);
      checkOutput("t1_hold_after_start", cpu_hold0, 1);
      checkOutput("t1_ready_after_start", in_ready0, 1);
      sendWord(32'h00300413, 0);
      checkOutput("t1_wr_en", wr_en0, 1);
      checkOutput("t1_wr_addr", wr_addr0, 32'h0000);
      checkOutput("t1_wr_data", wr_data0, 32'h00300413);
      checkOutput("t1_ready_in_write", in_ready0, 0);
      step();
      checkOutput("t1_done", done0, 1);
      checkOutput("t1_wr_en_after", wr_en0, 0);
      checkOutput("t1_hold_in_done", cpu_hold0, 1);
      checkOutput("t1_busy_in_done", busy0, 0);
      step();
      checkOutput("t1_done_drop", done0, 0);
      checkOutput("t1_hold_drop", cpu_hold0, 0);
      checkOutput("t1_write_count", addrLog0.size(), 1);
      checkOutput("t1_done_count", doneCount, 1);

      // T2: three words, hold and busy must stay high throughout
      clearLogs();
      pulseStart(14'd3);
      watchHold = 1'b1;
      sendWord(32'h00300413, 0);
      sendWord(32'h00100493, 0);
      sendWord(32'h01000913, 0);
      watchHold = 1'b0;
      checkOutput("t2_last_wr_addr", wr_addr0, 32'h0008);
      step();
      checkOutput("t2_done", done0, 1);
      checkOutput("t2_data_held", wr_data0, 32'h01000913);
      step();
      checkOutput("t2_write_count", addrLog0.size(), 3);
      checkOutput("t2_addr0", addrLog0[0], 32'h0000);
      checkOutput("t2_addr1", addrLog0[1], 32'h0004);
      checkOutput("t2_addr2", addrLog0[2], 32'h0008);
      checkOutput("t2_data0", dataLog0[0], 32'h00300413);
      checkOutput("t2_data1", dataLog0[1], 32'h00100493);
      checkOutput("t2_data2", dataLog0[2], 32'h01000913);
      checkOutput("t2_hold_busy_drops", holdDrop, 0);
      checkOutput("t2_done_count", doneCount, 1);

      // T3: random idle gaps between bytes
      clearLogs();
      pulseStart(14'd2);
      sendWord(32'h00100493, 5);
      sendWord(32'h00300413, 5);
      step();
      step();
      checkOutput("t3_write_count", addrLog0.size(), 2);
      checkOutput("t3_addr0", addrLog0[0], 32'h0000);
      checkOutput("t3_addr1", addrLog0[1], 32'h0004);
      checkOutput("t3_data0", dataLog0[0], 32'h00100493);
      checkOutput("t3_data1", dataLog0[1], 32'h00300413);
      checkOutput("t3_ready_in_write", readyInWrite, 0);

      // T4: zero-length load, then a start pulse ignored mid-load
      clearLogs();
      pulseStart(14'd0);
      checkOutput("t4_zero_done", done0, 1);
      checkOutput("t4_zero_hold", cpu_hold0, 1);
      checkOutput("t4_zero_busy", busy0, 0);
      checkOutput("t4_zero_wr_en", wr_en0, 0);
      step();
      checkOutput("t4_zero_done_drop", done0, 0);
      checkOutput("t4_zero_hold_drop", cpu_hold0, 0);
      checkOutput("t4_zero_no_write", addrLog0.size(), 0);
      pulseStart(14'd2);
      applyStimulus(8'h44, 0);
      applyStimulus(8'h33, 0);
      pulseStart(14'd1);
      applyStimulus(8'h22, 0);
      applyStimulus(8'h11, 0);
      sendWord(32'h55667788, 0);
      step();
      step();
      checkOutput("t4_write_count", addrLog0.size(), 2);
      checkOutput("t4_data0", dataLog0[0], 32'h11223344);
      checkOutput("t4_data1", dataLog0[1], 32'h55667788);
      checkOutput("t4_addr1", addrLog0[1], 32'h0004);
      checkOutput("t4_done_count", doneCount, 2);

      // T5: address wrap on the 0xFFFC-based instance
      clearLogs();
      pulseStart(14'd2);
      sendWord(32'h00500513, 0);
      sendWord(32'h00600593, 0);
      step();
      step();
      checkOutput("t5_wrap_count", addrLog1.size(), 2);
      checkOutput("t5_wrap_addr0", addrLog1[0], 32'hFFFC);
      checkOutput("t5_wrap_addr1", addrLog1[1], 32'h0000);
      checkOutput("t5_wrap_data1", dataLog1[1], 32'h00600593);
      checkOutput("t5_base0_addr1", addrLog0[1], 32'h0004);

      // T6: reset in the middle of a word, then a clean reload
      clearLogs();
      pulseStart(14'd2);
      applyStimulus(8'hAA, 0);
      applyStimulus(8'hBB, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      checkOutput("t6_ready_after_reset", in_ready0, 0);
      checkOutput("t6_hold_after_reset", cpu_hold0, 0);
      checkOutput("t6_busy_after_reset", busy0, 0);
      checkOutput("t6_data_after_reset", wr_data0, 0);
      checkOutput("t6_addr_after_reset", wr_addr0, 32'h0000);
      for (int i = 0; i < 6; i++) step();
      checkOutput("t6_no_write", addrLog0.size(), 0);
      checkOutput("t6_no_done", doneCount, 0);
      pulseStart(14'd1);
      sendWord(32'hDEADBEEF, 0);
      checkOutput("t6_reload_wr_en", wr_en0, 1);
      checkOutput("t6_reload_addr", wr_addr0, 32'h0000);
      checkOutput("t6_reload_data", wr_data0, 32'hDEADBEEF);
      step();
      step();
      checkOutput("t6_reload_count", addrLog0.size(), 1);

      checkOutput("handshake_timeouts", timeouts, 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
